// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : MEM pipeline stage. Decodes loads/stores from the EX/MEM
//            register, checks alignment, runs a request/response data-bus
//            transaction and formats the load result for MEM/WB.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            flush, hold        - pipeline flush, downstream stall
//            *_i                - EX/MEM register fields
//            waddr_o .. stallreq- MEM/WB fields and stall request
//            data_*             - data-bus master (addr_ok / data_ok handshake)
// Revision : 1.0 - initial release
// ============================================================================
module mem_access #(
   parameter logic [7:0] ALU_OP_LB  = 8'hE0,
   parameter logic [7:0] ALU_OP_LBU = 8'hE4,
   parameter logic [7:0] ALU_OP_LH  = 8'hE1,
   parameter logic [7:0] ALU_OP_LHU = 8'hE5,
   parameter logic [7:0] ALU_OP_LW  = 8'hE3,
   parameter logic [7:0] ALU_OP_SB  = 8'hE8,
   parameter logic [7:0] ALU_OP_SH  = 8'hE9,
   parameter logic [7:0] ALU_OP_SW  = 8'hEB
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        hold,
   input  logic [4:0]  waddr_i,
   input  logic        we_i,
   input  logic [31:0] wdata_i,
   input  logic [7:0]  aluop_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] reg2_i,
   input  logic [31:0] exc_i,
   input  logic [31:0] pc_i,
   output logic [4:0]  waddr_o,
   output logic        we_o,
   output logic [31:0] wdata_o,
   output logic [31:0] exc_o,
   output logic [31:0] badvaddr_o,
   output logic        stallreq,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ADDR     = 3'd1,
      S_DATA     = 3'd2,
      S_DONE     = 3'd3,
      S_ABT_ADDR = 3'd4,
      S_ABT_DATA = 3'd5
   } state_t;

   state_t      r_state;

   // Transaction copy taken at issue: after a flush the EX/MEM inputs move
   // on, but the bus fields must stay stable until the slave accepts them.
   logic [31:0] r_addr;
   logic [1:0]  r_size;
   logic        r_wr;
   logic [3:0]  r_wstrb;
   logic [31:0] r_wdata;
   logic [1:0]  r_lo;
   logic        r_signed;
   logic        r_load;
   logic        r_we;
   logic [4:0]  r_waddr;
   logic [31:0] r_rdata;

   logic        w_is_load;
   logic        w_is_store;
   logic        w_is_mem;
   logic        w_signed;
   logic [1:0]  w_size;
   logic        w_misalign;
   logic        w_exc_in;
   logic        w_issue_ok;
   logic [31:0] w_bus_addr;
   logic [3:0]  w_bus_wstrb;
   logic [31:0] w_bus_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_res;
   logic        w_unused;

   assign w_unused = ^pc_i;

   // ---------------------------------------------------------------- decode
   always_comb begin
      w_is_load  = 1'b0;
      w_is_store = 1'b0;
      w_signed   = 1'b0;
      w_size     = 2'd0;
      case (aluop_i)
         ALU_OP_LB:  begin w_is_load  = 1'b1; w_signed = 1'b1; w_size = 2'd0; end
         ALU_OP_LBU: begin w_is_load  = 1'b1;                  w_size = 2'd0; end
         ALU_OP_LH:  begin w_is_load  = 1'b1; w_signed = 1'b1; w_size = 2'd1; end
         ALU_OP_LHU: begin w_is_load  = 1'b1;                  w_size = 2'd1; end
         ALU_OP_LW:  begin w_is_load  = 1'b1;                  w_size = 2'd2; end
         ALU_OP_SB:  begin w_is_store = 1'b1;                  w_size = 2'd0; end
         ALU_OP_SH:  begin w_is_store = 1'b1;                  w_size = 2'd1; end
         ALU_OP_SW:  begin w_is_store = 1'b1;                  w_size = 2'd2; end
         default:    ;
      endcase
   end

   assign w_is_mem   = w_is_load | w_is_store;
   assign w_misalign = ((w_size == 2'd1) & addr_i[0]) |
                       ((w_size == 2'd2) & (addr_i[1:0] != 2'b00));
   assign w_exc_in   = (exc_i != 32'h0);
   assign w_issue_ok = w_is_mem & ~w_exc_in & ~w_misalign;
   assign w_bus_addr = (w_size == 2'd2) ? {addr_i[31:2], 2'b00} : addr_i;

   always_comb begin
      w_bus_wstrb = 4'b0000;
      w_bus_wdata = 32'h0;
      if (w_is_store) begin
         case (w_size)
            2'd0: begin
               w_bus_wstrb = 4'b0001 << addr_i[1:0];
               w_bus_wdata = {4{reg2_i[7:0]}};
            end
            2'd1: begin
               w_bus_wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
               w_bus_wdata = {2{reg2_i[15:0]}};
            end
            default: begin
               w_bus_wstrb = 4'b1111;
               w_bus_wdata = reg2_i;
            end
         endcase
      end
   end

   // ---------------------------------------------------- load result format
   always_comb begin
      case (r_lo)
         2'd0:    w_byte = r_rdata[7:0];
         2'd1:    w_byte = r_rdata[15:8];
         2'd2:    w_byte = r_rdata[23:16];
         default: w_byte = r_rdata[31:24];
      endcase
      w_half = r_lo[1] ? r_rdata[31:16] : r_rdata[15:0];
      case (r_size)
         2'd0:    w_load_res = r_signed ? {{24{w_byte[7]}}, w_byte}  : {24'h0, w_byte};
         2'd1:    w_load_res = r_signed ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
         default: w_load_res = r_rdata;
      endcase
   end

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_addr   <= 32'h0;
         r_size   <= 2'd0;
         r_wr     <= 1'b0;
         r_wstrb  <= 4'b0;
         r_wdata  <= 32'h0;
         r_lo     <= 2'd0;
         r_signed <= 1'b0;
         r_load   <= 1'b0;
         r_we     <= 1'b0;
         r_waddr  <= 5'd0;
         r_rdata  <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_issue_ok && !flush) begin
                  r_addr   <= w_bus_addr;
                  r_size   <= w_size;
                  r_wr     <= w_is_store;
                  r_wstrb  <= w_bus_wstrb;
                  r_wdata  <= w_bus_wdata;
                  r_lo     <= addr_i[1:0];
                  r_signed <= w_signed;
                  r_load   <= w_is_load;
                  r_we     <= we_i;
                  r_waddr  <= waddr_i;
                  r_state  <= data_addr_ok ? S_DATA : S_ADDR;
               end
            end
            S_ADDR: begin
               // data_data_ok is deliberately ignored here: a response can
               // only belong to this request once the address is accepted.
               if (data_addr_ok)
                  r_state <= flush ? S_ABT_DATA : S_DATA;
               else if (flush)
                  r_state <= S_ABT_ADDR;
            end
            S_DATA: begin
               if (data_data_ok) begin
                  if (flush) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_rdata <= data_rdata;
                     r_state <= S_DONE;
                  end
               end else if (flush) begin
                  r_state <= S_ABT_DATA;
               end
            end
            S_DONE: begin
               if (flush || !hold)
                  r_state <= S_IDLE;
            end
            S_ABT_ADDR: begin
               if (data_addr_ok)
                  r_state <= S_ABT_DATA;
            end
            S_ABT_DATA: begin
               if (data_data_ok)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // --------------------------------------------------------------- outputs
   // IDLE must be able to raise data_req in the same cycle the instruction
   // arrives, so outputs are decoded from the state and the live inputs.
   always_comb begin
      data_req   = 1'b0;
      data_wr    = r_wr;
      data_size  = r_size;
      data_addr  = r_addr;
      data_wstrb = r_wstrb;
      data_wdata = r_wdata;
      waddr_o    = 5'd0;
      we_o       = 1'b0;
      wdata_o    = 32'h0;
      exc_o      = 32'h0;
      badvaddr_o = 32'h0;
      stallreq   = 1'b0;
      if (!rst) begin
         case (r_state)
            S_IDLE: begin
               data_wr    = w_is_store;
               data_size  = w_size;
               data_addr  = w_bus_addr;
               data_wstrb = w_bus_wstrb;
               data_wdata = w_bus_wdata;
               if (!w_is_mem) begin
                  waddr_o = waddr_i;
                  we_o    = we_i;
                  wdata_o = wdata_i;
                  exc_o   = exc_i;
               end else if (w_exc_in) begin
                  waddr_o = waddr_i;
                  exc_o   = exc_i;
               end else if (w_misalign) begin
                  waddr_o    = waddr_i;
                  exc_o      = w_is_load ? 32'h0000_0010 : 32'h0000_0020;
                  badvaddr_o = addr_i;
               end else if (!flush) begin
                  data_req = 1'b1;
                  stallreq = 1'b1;
               end
            end
            S_ADDR, S_ABT_ADDR: begin
               data_req = 1'b1;
               stallreq = 1'b1;
            end
            S_DATA, S_ABT_DATA: begin
               stallreq = 1'b1;
            end
            S_DONE: begin
               waddr_o = r_waddr;
               we_o    = r_load & r_we;
               wdata_o = r_load ? w_load_res : 32'h0;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Self-checking bench for mem_access. Acts as EX/MEM source and
//            data-bus slave with random latencies; expected values come from
//            a transaction-level model of the load/store rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access;

   localparam logic [7:0] C_LB  = 8'hE0;
   localparam logic [7:0] C_LBU = 8'hE4;
   localparam logic [7:0] C_LH  = 8'hE1;
   localparam logic [7:0] C_LHU = 8'hE5;
   localparam logic [7:0] C_LW  = 8'hE3;
   localparam logic [7:0] C_SB  = 8'hE8;
   localparam logic [7:0] C_SH  = 8'hE9;
   localparam logic [7:0] C_SW  = 8'hEB;

   logic        clk = 1'b0;
   logic        rst, flush, hold;
   logic [4:0]  waddr_i;
   logic        we_i;
   logic [31:0] wdata_i, addr_i, reg2_i, exc_i, pc_i;
   logic [7:0]  aluop_i;
   logic [4:0]  waddr_o;
   logic        we_o, stallreq;
   logic [31:0] wdata_o, exc_o, badvaddr_o;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok, data_data_ok;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   mem_access dut (
      .clk(clk), .rst(rst), .flush(flush), .hold(hold),
      .waddr_i(waddr_i), .we_i(we_i), .wdata_i(wdata_i), .aluop_i(aluop_i),
      .addr_i(addr_i), .reg2_i(reg2_i), .exc_i(exc_i), .pc_i(pc_i),
      .waddr_o(waddr_o), .we_o(we_o), .wdata_o(wdata_o), .exc_o(exc_o),
      .badvaddr_o(badvaddr_o), .stallreq(stallreq),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------- reference model
   function automatic int op_bytes(input logic [7:0] op);
      if (op == C_LB || op == C_LBU || op == C_SB) return 1;
      if (op == C_LH || op == C_LHU || op == C_SH) return 2;
      if (op == C_LW || op == C_SW) return 4;
      return 0;
   endfunction

   function automatic bit op_load(input logic [7:0] op);
      return op == C_LB || op == C_LBU || op == C_LH || op == C_LHU || op == C_LW;
   endfunction

   function automatic bit misaligned(input logic [7:0] op, input logic [31:0] a);
      return (a % op_bytes(op)) != 0;
   endfunction

   function automatic logic [31:0] exp_addr(input logic [7:0] op, input logic [31:0] a);
      return (op_bytes(op) == 4) ? (a - (a % 4)) : a;
   endfunction

   function automatic logic [31:0] exp_size(input logic [7:0] op);
      return (op_bytes(op) == 1) ? 32'd0 : (op_bytes(op) == 2) ? 32'd1 : 32'd2;
   endfunction

   function automatic logic [31:0] exp_wstrb(input logic [7:0] op, input logic [31:0] a);
      return ((32'd1 << op_bytes(op)) - 32'd1) << (a % 4);
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [7:0] op, input logic [31:0] r);
      if (op_bytes(op) == 1) return (r & 32'hFF) * 32'h0101_0101;
      if (op_bytes(op) == 2) return (r & 32'hFFFF) * 32'h0001_0001;
      return r;
   endfunction

   function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] rd);
      logic [31:0] v;
      v = rd >> (8 * (a % 4));
      if (op_bytes(op) == 1) begin
         v = v & 32'hFF;
         if (op == C_LB && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (op_bytes(op) == 2) begin
         v = v & 32'hFFFF;
         if (op == C_LH && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   // --------------------------------------------------------------- stimulus
   task automatic set_in(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2,
                         input logic [4:0] wa, input logic we, input logic [31:0] wd,
                         input logic [31:0] ex);
      aluop_i = op; addr_i = a; reg2_i = r2; waddr_i = wa;
      we_i = we; wdata_i = wd; exc_i = ex; pc_i = $urandom;
   endtask

   // Single-cycle cases: non-memory, excepted or misaligned instructions.
   task automatic do_nomem(input string tg);
      #1;
      chk({tg, "_req"},   32'(data_req), 32'd0);
      chk({tg, "_stall"}, 32'(stallreq), 32'd0);
      if (op_bytes(aluop_i) == 0) begin
         chk({tg, "_we"},    32'(we_o),    32'(we_i));
         chk({tg, "_waddr"}, 32'(waddr_o), 32'(waddr_i));
         chk({tg, "_wdata"}, wdata_o,      wdata_i);
         chk({tg, "_exc"},   exc_o,        exc_i);
      end else if (exc_i != 0) begin
         chk({tg, "_we"},  32'(we_o), 32'd0);
         chk({tg, "_exc"}, exc_o,     exc_i);
      end else begin
         chk({tg, "_we"},  32'(we_o), 32'd0);
         chk({tg, "_exc"}, exc_o, op_load(aluop_i) ? 32'h10 : 32'h20);
         chk({tg, "_bad"}, badvaddr_o, addr_i);
      end
      @(posedge clk); #1;
   endtask

   // Full bus transaction for the instruction currently on the inputs.
   // Entered and left at posedge+1.
   task automatic do_mem(input int alat, input int dlat, input logic [31:0] rd,
                         input int hcnt, input string tg);
      int reqs = 0;
      int wd = -1;
      int stalls = 0;
      int cyc = 0;
      bit fin = 0;
      logic [31:0] res;
      while (!fin && cyc < 40) begin
         cyc++;
         data_addr_ok = 1'b0;
         data_data_ok = 1'b0;
         data_rdata   = $urandom;
         if (wd > 0) begin
            wd--;
            if (wd == 0) begin
               data_data_ok = 1'b1;
               data_rdata   = rd;
               wd = -1;
            end
         end
         #1;
         if (data_req) begin
            reqs++;
            chk({tg, "_addr"}, data_addr,       exp_addr(aluop_i, addr_i));
            chk({tg, "_wr"},   32'(data_wr),    op_load(aluop_i) ? 32'd0 : 32'd1);
            chk({tg, "_size"}, 32'(data_size),  exp_size(aluop_i));
            if (!op_load(aluop_i)) begin
               chk({tg, "_wstrb"}, 32'(data_wstrb), exp_wstrb(aluop_i, addr_i));
               chk({tg, "_wdat"},  data_wdata,      exp_wdata(aluop_i, reg2_i));
            end
            if (reqs == alat) begin
               data_addr_ok = 1'b1;
               wd = dlat;
            end
         end
         #1;
         if (stallreq) begin
            stalls++;
            @(posedge clk); #1;
         end else begin
            fin = 1;
         end
      end
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      if (!fin) begin
         chk({tg, "_timeout"}, 32'd1, 32'd0);
         @(posedge clk); #1;
         return;
      end
      chk({tg, "_nreq"},   32'(reqs),     32'(alat));
      chk({tg, "_stalls"}, 32'(stalls),   32'(alat + dlat));
      chk({tg, "_dreq"},   32'(data_req), 32'd0);
      chk({tg, "_exc"},    exc_o,         32'd0);
      res = exp_load(aluop_i, addr_i, rd);
      if (op_load(aluop_i)) begin
         chk({tg, "_we"},    32'(we_o),    32'(we_i));
         chk({tg, "_waddr"}, 32'(waddr_o), 32'(waddr_i));
         chk({tg, "_res"},   wdata_o,      res);
      end else begin
         chk({tg, "_we"}, 32'(we_o), 32'd0);
      end
      hold = (hcnt > 0);
      for (int i = 0; i < hcnt; i++) begin
         @(posedge clk); #2;
         chk({tg, "_hstall"}, 32'(stallreq), 32'd0);
         chk({tg, "_hreq"},   32'(data_req), 32'd0);
         if (op_load(aluop_i)) chk({tg, "_hres"}, wdata_o, res);
         hold = (i < hcnt - 1);
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [7:0] rand_nonmem();
      logic [7:0] op;
      op = 8'($urandom);
      while (op_bytes(op) != 0) op = 8'($urandom);
      return op;
   endfunction

   // ------------------------------------------------------------------ main
   initial begin
      logic [7:0] ops [8];
      logic [7:0] op;
      logic [31:0] a, ex;
      ops[0] = C_LB; ops[1] = C_LBU; ops[2] = C_LH; ops[3] = C_LHU;
      ops[4] = C_LW; ops[5] = C_SB;  ops[6] = C_SH; ops[7] = C_SW;

      rst = 1'b1; flush = 1'b0; hold = 1'b0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
      set_in(C_LW, 32'h0000_0100, 32'h0, 5'd3, 1'b1, 32'hDEAD_BEEF, 32'h0);
      @(posedge clk); @(posedge clk); #2;
      chk("rst_req",   32'(data_req),  32'd0);
      chk("rst_stall", 32'(stallreq),  32'd0);
      chk("rst_we",    32'(we_o),      32'd0);
      chk("rst_waddr", 32'(waddr_o),   32'd0);
      chk("rst_wdata", wdata_o,        32'd0);
      chk("rst_exc",   exc_o,          32'd0);
      chk("rst_bad",   badvaddr_o,     32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // LW with addr_ok after 2 waiting cycles, data one cycle later
      do_mem(3, 1, 32'h1234_5678, 0, "lw_basic");
      set_in(C_LB,  32'h0000_0013, 32'h0, 5'd4, 1'b1, 32'h0, 32'h0);
      do_mem(1, 1, 32'h80FF_FFFF, 0, "lb_sx");
      set_in(C_LBU, 32'h0000_0013, 32'h0, 5'd5, 1'b1, 32'h0, 32'h0);
      do_mem(2, 2, 32'h80FF_FFFF, 0, "lbu_zx");
      set_in(C_LH,  32'h0000_0022, 32'h0, 5'd6, 1'b1, 32'h0, 32'h0);
      do_mem(1, 3, 32'h8001_4321, 0, "lh_sx");
      set_in(C_SH,  32'h0000_0006, 32'hAAAA_5555, 5'd7, 1'b1, 32'h0, 32'h0);
      do_mem(2, 1, 32'h0, 0, "sh");
      set_in(C_LW,  32'h0000_0002, 32'h0, 5'd8, 1'b1, 32'h0, 32'h0);
      do_nomem("lw_mis");
      set_in(C_SW,  32'h0000_0041, 32'h0, 5'd8, 1'b1, 32'h0, 32'h0);
      do_nomem("sw_mis");
      set_in(C_LW,  32'h0000_0200, 32'h0, 5'd9, 1'b1, 32'h0, 32'h0);
      do_mem(1, 1, 32'hCAFE_F00D, 3, "lw_hold");
      set_in(C_LBU, 32'h0000_0300, 32'h0, 5'd9, 1'b1, 32'h0, 32'h0000_0400);
      do_nomem("exc_in");

      // flush while the address is still pending
      set_in(C_LW, 32'h0000_1000, 32'h0, 5'd10, 1'b1, 32'h0, 32'h0);
      #1; chk("fa_req0", 32'(data_req), 32'd1);
      @(posedge clk); #1;
      flush = 1'b1;
      #1; chk("fa_req1", 32'(data_req), 32'd1);
      @(posedge clk); #1;
      flush = 1'b0;
      set_in(C_SW, 32'h0000_2008, 32'h1357_9BDF, 5'd11, 1'b0, 32'h0, 32'h0);
      #1;
      chk("fa_req2",   32'(data_req), 32'd1);
      chk("fa_addr2",  data_addr,     32'h0000_1000);
      chk("fa_wr2",    32'(data_wr),  32'd0);
      chk("fa_stall2", 32'(stallreq), 32'd1);
      chk("fa_we2",    32'(we_o),     32'd0);
      chk("fa_exc2",   exc_o,         32'd0);
      @(posedge clk); #1;
      data_addr_ok = 1'b1;
      #1;
      chk("fa_req3",  32'(data_req), 32'd1);
      chk("fa_addr3", data_addr,     32'h0000_1000);
      @(posedge clk); #1;
      data_addr_ok = 1'b0;
      #1;
      chk("fa_req4",   32'(data_req), 32'd0);
      chk("fa_stall4", 32'(stallreq), 32'd1);
      chk("fa_we4",    32'(we_o),     32'd0);
      data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      data_data_ok = 1'b0;
      do_mem(1, 1, 32'h0, 0, "fa_sw");

      // flush while waiting for data
      set_in(C_LW, 32'h0000_3000, 32'h0, 5'd12, 1'b1, 32'h0, 32'h0);
      data_addr_ok = 1'b1;
      #1; chk("fd_req", 32'(data_req), 32'd1);
      @(posedge clk); #1;
      data_addr_ok = 1'b0;
      flush = 1'b1;
      #1; chk("fd_stall", 32'(stallreq), 32'd1);
      @(posedge clk); #1;
      flush = 1'b0;
      set_in(8'h21, 32'h0, 32'h0, 5'd13, 1'b1, 32'h5555_0000, 32'h0);
      data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
      #1;
      chk("fd_we",     32'(we_o),     32'd0);
      chk("fd_stall2", 32'(stallreq), 32'd1);
      @(posedge clk); #1;
      data_data_ok = 1'b0;
      do_nomem("fd_after");

      // flush in IDLE suppresses the issue
      set_in(C_SB, 32'h0000_4001, 32'hFF, 5'd1, 1'b0, 32'h0, 32'h0);
      flush = 1'b1;
      #1;
      chk("fi_req",   32'(data_req), 32'd0);
      chk("fi_stall", 32'(stallreq), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;

      // reset during an outstanding transaction; late response ignored
      set_in(C_LW, 32'h0000_5000, 32'h0, 5'd2, 1'b1, 32'h0, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      set_in(8'h25, 32'h0, 32'h0, 5'd14, 1'b1, 32'h0BAD_0BAD, 32'h0);
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
      #1;
      chk("rr_stall", 32'(stallreq), 32'd0);
      chk("rr_wdata", wdata_o,       32'h0BAD_0BAD);
      @(posedge clk); #1;
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      do_nomem("rr_after");

      // randomized mix
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 4) == 0) op = rand_nonmem();
         else op = ops[$urandom_range(0, 7)];
         a  = $urandom;
         if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
         ex = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h1) : 32'h0;
         set_in(op, a, $urandom, 5'($urandom), 1'($urandom), $urandom, ex);
         if (op_bytes(op) == 0 || ex != 0 || misaligned(op, a))
            do_nomem("rnd_s");
         else
            do_mem($urandom_range(1, 3), $urandom_range(1, 3), $urandom,
                   $urandom_range(0, 2), "rnd_m");
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
